sev_seg_scan_ctrl: RTL and testbench

Scan controller for the 4-digit multiplexed seven-segment display on the divider board. It divides the system clock into per-digit time slots and inserts a blanking gap between digits to prevent ghosting. It double-buffers the displayed value so that a new value from the divider is committed only at a frame boundary, and it can suppress leading zeros. Its outputs drive the digit enables and the nibble input of the existing seven-segment decoder.

---
 rtl/sev_seg_scan_ctrl.sv | 105 ++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// Four-digit multiplexed 7-seg scan: per-slot blanking, frame-aligned double buffer, leading-zero blanking.
// Outputs registered, one cycle behind the prescaler; a load while busy is dropped (no queueing).
module sev_seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        lz_blank_en,
    output logic        busy,
    output logic        load_ack,
    output logic        frame_start,
    output logic [3:0]  led_enable,
    output logic [3:0]  digit_val
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    phase_t        phase;
    logic [15:0]   active_buf;
    logic [15:0]   shadow_buf;

    logic          drive_next;
    logic          suppress;
    logic          commit;
    logic [3:0]    slot_nib;
    logic [3:0]    slot_pat;

    // phase holds the unmasked blank/drive state of the previous cycle within the slot
    always_comb begin
        drive_next = (cnt == CNT_BLANK) || ((cnt != '0) && (phase == PH_DRIVE));
        commit     = (slot == 2'd3) && (cnt == CNT_LAST);
        slot_nib   = active_buf[3:0];
        slot_pat   = 4'b1110;
        suppress   = 1'b0;
        case (slot)
            2'd0: begin
                slot_nib = active_buf[15:12];
                slot_pat = 4'b0111;
                suppress = lz_blank_en && (active_buf[15:12] == 4'h0);
            end
            2'd1: begin
                slot_nib = active_buf[11:8];
                slot_pat = 4'b1011;
                suppress = lz_blank_en && (active_buf[15:8] == 8'h00);
            end
            2'd2: begin
                slot_nib = active_buf[7:4];
                slot_pat = 4'b1101;
                suppress = lz_blank_en && (active_buf[15:4] == 12'h000);
            end
            default: begin
                slot_nib = active_buf[3:0];
                slot_pat = 4'b1110;
                suppress = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            slot        <= 2'd0;
            phase       <= PH_BLANK;
            active_buf  <= 16'h0000;
            shadow_buf  <= 16'h0000;
            busy        <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            led_enable  <= 4'hF;
            digit_val   <= 4'h0;
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                slot <= slot + 2'd1;
            end
            phase       <= drive_next ? PH_DRIVE : PH_BLANK;
            led_enable  <= (drive_next && !suppress) ? slot_pat : 4'hF;
            digit_val   <= slot_nib;
            frame_start <= (slot == 2'd0) && (cnt == '0);
            load_ack    <= commit && busy;

            // a load arriving in the commit cycle is dropped because busy is still set
            if (commit && busy) begin
                active_buf <= shadow_buf;
                busy       <= 1'b0;
            end else if (load && !busy) begin
                shadow_buf <= digits_in;
                busy       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Bench for sev_seg_scan_ctrl: instance a (SCAN_DIV=8, BLANK_CYC=2) and instance b (SCAN_DIV=4, BLANK_CYC=0).
module tb_sev_seg_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        load    = 1'b0;
    logic        lz      = 1'b0;
    logic [15:0] din     = 16'h0;
    logic        b_load  = 1'b0;
    logic        b_lz    = 1'b0;
    logic [15:0] b_din   = 16'h0;

    logic       a_busy, a_ack, a_fs;
    logic [3:0] a_led, a_dv;
    logic       b_busy, b_ack, b_fs;
    logic [3:0] b_led, b_dv;

    sev_seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut_a (
        .clk(clk), .reset_n(reset_n), .load(load), .digits_in(din), .lz_blank_en(lz),
        .busy(a_busy), .load_ack(a_ack), .frame_start(a_fs), .led_enable(a_led), .digit_val(a_dv)
    );

    sev_seg_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .load(b_load), .digits_in(b_din), .lz_blank_en(b_lz),
        .busy(b_busy), .load_ack(b_ack), .frame_start(b_fs), .led_enable(b_led), .digit_val(b_dv)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // reference model: e = clock edges since reset release; edge e shows output position e-1
    int          e      = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_busy = 1'b0;
    logic        m_ack  = 1'b0;
    logic [3:0]  x_led  = 4'hF;
    logic [3:0]  x_dv   = 4'h0;
    logic        x_fs   = 1'b0;
    logic [3:0]  xb_led = 4'hF;
    logic        xb_fs  = 1'b0;

    int ack_seen = 0;
    int fs_seen  = 0;
    int hi_seen  = 0;
    int nblank   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        e = 0; m_disp = 16'h0; m_pend = 16'h0; m_busy = 1'b0; m_ack = 1'b0;
        x_led = 4'hF; x_dv = 4'h0; x_fs = 1'b0; xb_led = 4'hF; xb_fs = 1'b0;
    endtask

    task automatic model_edge();
        int p, s, c, sb;
        logic was_busy, sup;
        e++;
        p  = e - 1;
        s  = (p / SD) % 4;
        c  = p % SD;
        sb = (p / 4) % 4;
        sup    = lz && (s < 3) && ((m_disp >> (4 * (3 - s))) == 16'h0);
        x_led  = (c < BC || sup) ? 4'hF : ~(4'b1000 >> s);
        x_dv   = 4'((m_disp >> (4 * (3 - s))) & 16'hF);
        x_fs   = (p % FR == 0);
        xb_led = ~(4'b1000 >> sb);
        xb_fs  = (p % 16 == 0);
        was_busy = m_busy;
        m_ack    = 1'b0;
        if ((p % FR == FR - 1) && m_busy) begin
            m_disp = m_pend; m_busy = 1'b0; m_ack = 1'b1;
        end
        if (load && !was_busy) begin
            m_pend = din; m_busy = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("a_led_enable", 16'(a_led), 16'(x_led));
        chk("a_digit_val", 16'(a_dv), 16'(x_dv));
        chk("a_busy", 16'(a_busy), 16'(m_busy));
        chk("a_load_ack", 16'(a_ack), 16'(m_ack));
        chk("a_frame_start", 16'(a_fs), 16'(x_fs));
        chk("b_led_enable", 16'(b_led), 16'(xb_led));
        chk("b_digit_val", 16'(b_dv), 16'h0);
        chk("b_frame_start", 16'(b_fs), 16'(xb_fs));
        chk("b_busy_ack", 16'({b_busy, b_ack}), 16'h0);
        if (a_ack) ack_seen++;
        if (a_fs) fs_seen++;
        if (a_dv > 4'd9) hi_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic align(input int target);
        int k = 0;
        while (((e - 1) % FR) != target && k < 4 * FR) begin
            tick();
            k++;
        end
        chk("align_bound", 16'(((e - 1) % FR) == target), 16'h1);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load = 1'b1; din = v;
        tick();
        load = 1'b0;
    endtask

    task automatic count_blank_frame(output int n);
        align(FR - 1);
        n = 0;
        repeat (FR) begin
            tick();
            if (a_led == 4'hF) n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_led"}, 16'(a_led), 16'hF);
        chk({tag, "_busy"}, 16'(a_busy), 16'h0);
        chk({tag, "_ack_fs"}, 16'({a_ack, a_fs}), 16'h0);
        chk({tag, "_dv"}, 16'(a_dv), 16'h0);
        chk({tag, "_b_led"}, 16'(b_led), 16'hF);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        run(2);
        reset_n = 1'b1;

        // free running, lz off, buffer zero
        fs_seen = 0;
        run(64);
        chk("frame_start_count", 16'(fs_seen), 16'd2);

        // load during slot 1, then a second load while busy
        align(9);
        pulse_load(16'h1234);
        chk("busy_after_load", 16'(a_busy), 16'h1);
        ack_seen = 0;
        hi_seen  = 0;
        run(3);
        pulse_load(16'hABCD);
        align(FR - 1);
        chk("ack_at_frame_end", 16'(a_ack), 16'h1);
        align(2);
        chk("slot0_digit", 16'(a_dv), 16'h1);
        align(10);
        chk("slot1_digit", 16'(a_dv), 16'h2);
        align(18);
        chk("slot2_digit", 16'(a_dv), 16'h3);
        align(26);
        chk("slot3_digit", 16'(a_dv), 16'h4);
        chk("single_ack", 16'(ack_seen), 16'd1);
        chk("no_ignored_value", 16'(hi_seen), 16'd0);

        // leading-zero suppression
        lz = 1'b1;
        pulse_load(16'h0050);
        count_blank_frame(nblank);
        chk("lz_0050_blank_cycles", 16'(nblank), 16'd20);
        pulse_load(16'h0000);
        count_blank_frame(nblank);
        chk("lz_0000_blank_cycles", 16'(nblank), 16'd26);
        pulse_load(16'h1004);
        count_blank_frame(nblank);
        chk("lz_1004_blank_cycles", 16'(nblank), 16'd8);

        // reset in slot 2 with a pending value
        lz = 1'b0;
        pulse_load(16'hBEEF);
        align(20);
        chk("busy_before_reset", 16'(a_busy), 16'h1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        run(2);
        reset_n  = 1'b1;
        ack_seen = 0;
        run(2 * FR);
        chk("no_ack_after_reset", 16'(ack_seen), 16'd0);

        // randomized loads and lz toggling
        for (int i = 0; i < 800; i++) begin
            if (i % 8 == 0) lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                load = 1'b1;
                din  = 16'($urandom);
            end else begin
                load = 1'b0;
            end
            tick();
        end
        load = 1'b0;
        run(FR);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
